// File: rtl/ascon_perm_sliced.sv
// ---------------------------------------------------------------------------
// ascon_perm_sliced
//   Multi-cycle Ascon permutation core (p^a / p^b) on a 320-bit state.
//   Each round takes three phases: constant addition (1 cycle), a bit-sliced
//   S-box layer handling LANES columns per cycle (64/LANES cycles), and the
//   linear diffusion layer (1 cycle). One round therefore takes 2+64/LANES
//   cycles.
//
// Parameters
//   LANES    S-box columns per cycle: 1,2,4,8,16,32 or 64
//   MAX_RND  round-count ceiling; larger requests are clamped to it
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (aborts a run, no done)
//   start      run request, sampled only while busy=0
//   rnd[3:0]   number of rounds, latched on an accepted start
//   s_in[319:0]  input state {x0,x1,x2,x3,x4}, x0 = [319:256]
//   abort      (only with ASCON_PERM_ABORT_EN) cancel a run in progress
//   busy       high from the edge after acceptance until done
//   done       one-cycle pulse; s_out is valid from this cycle
//   s_out[319:0] permuted state, held until the next done
//   dbg_state[1:0] FSM state: 0 IDLE, 1 CONST, 2 SBOX, 3 LINEAR
//
// Handshake: a run is accepted on any edge where start=1 and busy=0; the
//   result is announced by a single-cycle done pulse and s_out then stays
//   stable until the following done. start while busy is dropped.
//
// Optional feature macro: ASCON_PERM_ABORT_EN adds the abort input.
// ---------------------------------------------------------------------------
module ascon_perm_sliced #(
  parameter int LANES   = 8,
  parameter int MAX_RND = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   rnd,
  input  logic [319:0] s_in,
`ifdef ASCON_PERM_ABORT_EN
  input  logic         abort,
`endif
  output logic         busy,
  output logic         done,
  output logic [319:0] s_out,
  output logic [1:0]   dbg_state
);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 &&
        LANES != 16 && LANES != 32 && LANES != 64) begin : g_bad_lanes
      $error("ascon_perm_sliced: LANES must be one of 1,2,4,8,16,32,64");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONST  = 2'd1,
    S_SBOX   = 2'd2,
    S_LINEAR = 2'd3
  } state_t;

  localparam logic [3:0] MAX_RN   = 4'(MAX_RND);
  localparam logic [5:0] COL_LAST = 6'(64 - LANES);
  localparam logic [5:0] COL_STEP = 6'(LANES);  // 64 wraps to 0: one pass

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // r_x[4] is x0 (MSB word of the state), r_x[0] is x4.
  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0][63:0] r_x;
  logic [3:0]       r_rn;
  logic [3:0]       r_i;
  logic [5:0]       r_col;
  logic             r_busy;
  logic             r_done;
  logic [319:0]     r_s_out;

  logic [3:0]       w_rn_clamped;
  logic [3:0]       w_r;
  logic [7:0]       w_c;
  logic [4:0][63:0] w_sb;
  logic [4:0][63:0] w_lin;
  logic             w_last;
  logic             w_abort;

  assign w_rn_clamped = (rnd > MAX_RN) ? MAX_RN : rnd;
  // Round constant index counts up to 11 on the final round for any rn.
  assign w_r    = 4'd12 - r_rn + r_i;
  assign w_c    = {4'hf - w_r, w_r};
  assign w_last = (r_i == r_rn - 4'd1);

`ifdef ASCON_PERM_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // S-box layer on columns r_col .. r_col+LANES-1; x0 supplies the MSB.
  always_comb begin
    logic [5:0] j;
    logic [4:0] v;
    logic [4:0] o;
    w_sb = r_x;
    j    = '0;
    v    = '0;
    o    = '0;
    for (int k = 0; k < LANES; k++) begin
      j = r_col + 6'(k);
      v = {r_x[4][j], r_x[3][j], r_x[2][j], r_x[1][j], r_x[0][j]};
      o = SBOX[v];
      w_sb[4][j] = o[4];
      w_sb[3][j] = o[3];
      w_sb[2][j] = o[2];
      w_sb[1][j] = o[1];
      w_sb[0][j] = o[0];
    end
  end

  // Linear diffusion layer.
  always_comb begin
    w_lin[4] = r_x[4] ^ ror(r_x[4], 19) ^ ror(r_x[4], 28);
    w_lin[3] = r_x[3] ^ ror(r_x[3], 61) ^ ror(r_x[3], 39);
    w_lin[2] = r_x[2] ^ ror(r_x[2], 1)  ^ ror(r_x[2], 6);
    w_lin[1] = r_x[1] ^ ror(r_x[1], 10) ^ ror(r_x[1], 17);
    w_lin[0] = r_x[0] ^ ror(r_x[0], 7)  ^ ror(r_x[0], 41);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && (rnd != 4'd0)) w_state_nxt = S_CONST;
      S_CONST:  w_state_nxt = S_SBOX;
      S_SBOX:   if (r_col == COL_LAST) w_state_nxt = S_LINEAR;
      S_LINEAR: w_state_nxt = w_last ? S_IDLE : S_CONST;
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_rn    <= '0;
      r_i     <= '0;
      r_col   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_s_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_abort) begin
        r_busy <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (rnd == 4'd0) begin
                // Zero rounds: identity, answered on the accepting edge.
                r_s_out <= s_in;
                r_done  <= 1'b1;
              end else begin
                r_x    <= s_in;
                r_rn   <= w_rn_clamped;
                r_i    <= '0;
                r_col  <= '0;
                r_busy <= 1'b1;
              end
            end
          end
          S_CONST: r_x[2] <= r_x[2] ^ {56'd0, w_c};
          S_SBOX: begin
            r_x   <= w_sb;
            r_col <= r_col + COL_STEP;
          end
          S_LINEAR: begin
            r_x <= w_lin;
            r_i <= r_i + 4'd1;
            if (w_last) begin
              r_s_out <= w_lin;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign s_out     = r_s_out;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_ascon_perm_sliced.sv
// ---------------------------------------------------------------------------
// tb_ascon_perm_sliced
//   Three instances (LANES = 8, 64, 1) share clock, reset, rnd and s_in; each
//   has its own start. Results, latencies and busy lengths are compared with
//   a plain word-level Ascon model written from the round definition.
// ---------------------------------------------------------------------------
module tb_ascon_perm_sliced;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start8, start64, start1;
  logic [3:0]   rnd;
  logic [319:0] s_in;
`ifdef ASCON_PERM_ABORT_EN
  logic         abort;
`endif
  logic         busy8, busy64, busy1;
  logic         done8, done64, done1;
  logic [319:0] sout8, sout64, sout1;
  logic [1:0]   st8, st64, st1;

  ascon_perm_sliced #(.LANES(8), .MAX_RND(12)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .rnd(rnd), .s_in(s_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .busy(busy8), .done(done8), .s_out(sout8), .dbg_state(st8)
  );

  ascon_perm_sliced #(.LANES(64), .MAX_RND(12)) u_dut64 (
    .clk(clk), .reset(reset), .start(start64), .rnd(rnd), .s_in(s_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .busy(busy64), .done(done64), .s_out(sout64), .dbg_state(st64)
  );

  ascon_perm_sliced #(.LANES(1), .MAX_RND(12)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .rnd(rnd), .s_in(s_in),
`ifdef ASCON_PERM_ABORT_EN
    .abort(abort),
`endif
    .busy(busy1), .done(done1), .s_out(sout1), .dbg_state(st1)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [319:0] obs,
                       input logic [319:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [32] = '{
    8'h04, 8'h0b, 8'h1f, 8'h14, 8'h1a, 8'h15, 8'h09, 8'h02,
    8'h1b, 8'h05, 8'h08, 8'h12, 8'h1d, 8'h03, 8'h06, 8'h1c,
    8'h1e, 8'h13, 8'h07, 8'h0e, 8'h00, 8'h0d, 8'h11, 8'h18,
    8'h10, 8'h0c, 8'h01, 8'h19, 8'h16, 8'h0a, 8'h0f, 8'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s,
                                              input int rn);
    logic [63:0] x [5];
    logic [7:0]  o;
    int          v;
    int          r;
    for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
    for (int i = 0; i < rn; i++) begin
      r = 12 - rn + i;
      x[2] = x[2] ^ 64'(((15 - r) * 16) + r);
      for (int j = 0; j < 64; j++) begin
        v = 16*int'(x[0][j]) + 8*int'(x[1][j]) + 4*int'(x[2][j])
          + 2*int'(x[3][j]) + int'(x[4][j]);
        o = sbox_t[v];
        x[0][j] = o[4];
        x[1][j] = o[3];
        x[2][j] = o[2];
        x[3][j] = o[1];
        x[4][j] = o[0];
      end
      x[0] = x[0] ^ rotr(x[0], 19) ^ rotr(x[0], 28);
      x[1] = x[1] ^ rotr(x[1], 61) ^ rotr(x[1], 39);
      x[2] = x[2] ^ rotr(x[2], 1)  ^ rotr(x[2], 6);
      x[3] = x[3] ^ rotr(x[3], 10) ^ rotr(x[3], 17);
      x[4] = x[4] ^ rotr(x[4], 7)  ^ rotr(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] v;
    for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- instance selection helpers ----------------
  function automatic int lanes_of(input int u);
    case (u)
      0:       return 8;
      1:       return 64;
      default: return 1;
    endcase
  endfunction

  function automatic logic get_busy(input int u);
    case (u)
      0:       return busy8;
      1:       return busy64;
      default: return busy1;
    endcase
  endfunction

  function automatic logic get_done(input int u);
    case (u)
      0:       return done8;
      1:       return done64;
      default: return done1;
    endcase
  endfunction

  function automatic logic [319:0] get_sout(input int u);
    case (u)
      0:       return sout8;
      1:       return sout64;
      default: return sout1;
    endcase
  endfunction

  task automatic set_start(input int u, input logic v);
    case (u)
      0:       start8  = v;
      1:       start64 = v;
      default: start1  = v;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; returns #1 after the done edge so that a
  // following call starts in the done cycle (back-to-back).
  task automatic run_perm(input int u, input logic [3:0] r,
                          input logic [319:0] st, input bit disturb,
                          input bit chk_busy);
    int           rn, lat, busy_cnt, exp_lat, limit;
    logic [319:0] exp;
    rn      = (int'(r) > 12) ? 12 : int'(r);
    exp     = model_perm(st, rn);
    exp_lat = rn * (2 + 64 / lanes_of(u));
    rnd  = r;
    s_in = st;
    set_start(u, 1'b1);
    @(posedge clk); #1;
    set_start(u, 1'b0);
    if (rn == 0) begin
      check("rnd0_done", 320'(get_done(u)), 320'(1));
      check("rnd0_sout", get_sout(u), st);
      check("rnd0_busy", 320'(get_busy(u)), 320'(0));
      return;
    end
    check("done_clear", 320'(get_done(u)), 320'(0));
    lat      = 0;
    busy_cnt = get_busy(u) ? 1 : 0;
    limit    = exp_lat + 20;
    while (!get_done(u) && lat < limit) begin
      if (disturb && lat == 5) begin
        set_start(u, 1'b1);
        s_in = rand_state();
        rnd  = 4'($urandom_range(1, 15));
      end
      if (disturb && lat == 6) set_start(u, 1'b0);
      @(posedge clk); #1;
      lat++;
      if (get_busy(u)) busy_cnt++;
    end
    check("latency", 320'(lat), 320'(exp_lat));
    check("s_out", get_sout(u), exp);
    if (chk_busy) check("busy_cycles", 320'(busy_cnt), 320'(exp_lat));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [319:0] st, prev;
    int           n_done;
    reset   = 1'b1;
    start8  = 1'b0;
    start64 = 1'b0;
    start1  = 1'b0;
    rnd     = '0;
    s_in    = '0;
`ifdef ASCON_PERM_ABORT_EN
    abort   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state of all instances
    check("rst_busy8",  320'(busy8),  320'(0));
    check("rst_done8",  320'(done8),  320'(0));
    check("rst_sout8",  sout8,        320'(0));
    check("rst_st8",    320'(st8),    320'(0));
    check("rst_busy64", 320'(busy64), 320'(0));
    check("rst_sout64", sout64,       320'(0));
    check("rst_st64",   320'(st64),   320'(0));
    check("rst_busy1",  320'(busy1),  320'(0));
    check("rst_sout1",  sout1,        320'(0));
    check("rst_st1",    320'(st1),    320'(0));

    // LANES=64, one round on the zero state: known words
    run_perm(1, 4'd1, 320'd0, 1'b0, 1'b1);
    check("p1_x0", 320'(sout64[319:256]), 320'(64'h000964b00000004b));
    check("p1_x2", 320'(sout64[191:128]), 320'(64'h53ffffffffffff90));
    check("p1_x4", 320'(sout64[63:0]),    320'(0));

    // LANES=8, 200 random p12 runs, back-to-back; one run disturbed mid-way
    for (int n = 0; n < 200; n++)
      run_perm(0, 4'd12, rand_state(), (n == 10), 1'b1);
    @(posedge clk); #1;
    check("done_pulse", 320'(done8), 320'(0));

    // LANES=1: p6 and clamped p12
    run_perm(2, 4'd6, rand_state(), 1'b0, 1'b1);
    run_perm(2, 4'd15, rand_state(), 1'b0, 1'b1);

    // Mixed round counts on LANES=8 and LANES=64
    for (int n = 0; n < 8; n++)
      run_perm(n % 2, 4'($urandom_range(1, 15)), rand_state(), 1'b0, 1'b0);

    // Zero rounds: identity on the accepting edge, busy never raised
    @(posedge clk); #1;
    run_perm(0, 4'd0, {40{8'hA5}}, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rnd0_pulse", 320'(done8), 320'(0));
    check("rnd0_busy2", 320'(busy8), 320'(0));
    check("rnd0_hold",  sout8, {40{8'hA5}});

    // Reset in the middle of a run
    st   = rand_state();
    rnd  = 4'd12;
    s_in = st;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (49) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_busy", 320'(busy8), 320'(0));
    check("mrst_done", 320'(done8), 320'(0));
    check("mrst_sout", sout8, 320'(0));
    n_done = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done8) n_done++;
    end
    check("mrst_nodone", 320'(n_done), 320'(0));
    run_perm(0, 4'd12, rand_state(), 1'b0, 1'b1);

`ifdef ASCON_PERM_ABORT_EN
    // Abort mid-run: back to idle, previous result kept, no done
    prev   = sout8;
    rnd    = 4'd12;
    s_in   = rand_state();
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 320'(busy8), 320'(0));
    check("abort_done", 320'(done8), 320'(0));
    check("abort_sout", sout8, prev);
    n_done = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done8) n_done++;
    end
    check("abort_nodone", 320'(n_done), 320'(0));
    // Abort while idle does nothing
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle_busy", 320'(busy8), 320'(0));
    check("abort_idle_sout", sout8, prev);
    run_perm(0, 4'd8, rand_state(), 1'b0, 1'b1);
`else
    prev = sout8;
    repeat (3) @(posedge clk);
    #1;
    check("hold_sout", sout8, prev);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
